// File: rtl/ct_ifu_icache_tag_req_arb_if.sv
// ============================================================================
// Module   : ct_ifu_icache_tag_req_arb_if
// Brief    : Request/grant and tag-array access bundle for the icache tag arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ct_ifu_icache_tag_req_arb_if;
    logic        cp0_ifu_icache_inv_req;
    logic        ifu_icache_inv_done;

    logic        refill_tag_wr_vld;
    logic [15:0] refill_tag_index;
    logic        refill_tag_way;
    logic [27:0] refill_tag_value;
    logic        refill_tag_wr_gnt;

    logic        lru_upd_vld;
    logic [15:0] lru_upd_index;
    logic        lru_upd_bit;
    logic        lru_upd_gnt;

    logic        fetch_tag_rd_vld;
    logic [15:0] fetch_tag_index;
    logic        fetch_tag_rd_gnt;

    logic [15:0] ifu_icache_index;
    logic        ifu_icache_tag_cen_b;
    logic        ifu_icache_tag_clk_en;
    logic [58:0] ifu_icache_tag_din;
    logic [2:0]  ifu_icache_tag_wen;

    modport slave (
        input  cp0_ifu_icache_inv_req,
        input  refill_tag_wr_vld, refill_tag_index, refill_tag_way, refill_tag_value,
        input  lru_upd_vld, lru_upd_index, lru_upd_bit,
        input  fetch_tag_rd_vld, fetch_tag_index,
        output ifu_icache_inv_done,
        output refill_tag_wr_gnt, lru_upd_gnt, fetch_tag_rd_gnt,
        output ifu_icache_index, ifu_icache_tag_cen_b, ifu_icache_tag_clk_en,
        output ifu_icache_tag_din, ifu_icache_tag_wen
    );

    modport master (
        output cp0_ifu_icache_inv_req,
        output refill_tag_wr_vld, refill_tag_index, refill_tag_way, refill_tag_value,
        output lru_upd_vld, lru_upd_index, lru_upd_bit,
        output fetch_tag_rd_vld, fetch_tag_index,
        input  ifu_icache_inv_done,
        input  refill_tag_wr_gnt, lru_upd_gnt, fetch_tag_rd_gnt,
        input  ifu_icache_index, ifu_icache_tag_cen_b, ifu_icache_tag_clk_en,
        input  ifu_icache_tag_din, ifu_icache_tag_wen
    );
endinterface

`default_nettype wire

// File: rtl/ct_ifu_icache_tag_req_arb.sv
// ============================================================================
// Module   : ct_ifu_icache_tag_req_arb
// Brief    : Icache tag-array port arbiter with invalidate-all sweep after reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ct_ifu_icache_tag_req_arb #(
    parameter int WIDTH = 12
) (
    input  logic                                forever_cpuclk,
    input  logic                                cpurst,
    ct_ifu_icache_tag_req_arb_if.slave          bus
);

    localparam int              CNT_W    = WIDTH - 4;
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    localparam logic [0:0] SWEEP = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sweep;
    logic             w_last;

    // Reset forces the set-0 sweep write combinationally so the array sees it
    // even while the state register still holds a stale value.
    assign w_sweep = cpurst | (r_state == SWEEP);
    assign w_last  = (r_cnt == CNT_LAST);

    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            r_state <= SWEEP;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SWEEP: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt   <= r_cnt + CNT_ONE;
                    end
                end
                IDLE: begin
                    if (bus.cp0_ifu_icache_inv_req) begin
                        r_state <= SWEEP;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= SWEEP;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.ifu_icache_inv_done   = 1'b0;
        bus.refill_tag_wr_gnt     = 1'b0;
        bus.lru_upd_gnt           = 1'b0;
        bus.fetch_tag_rd_gnt      = 1'b0;
        bus.ifu_icache_index      = 16'd0;
        bus.ifu_icache_tag_cen_b  = 1'b1;
        bus.ifu_icache_tag_clk_en = 1'b0;
        bus.ifu_icache_tag_wen    = 3'b111;
        bus.ifu_icache_tag_din    = 59'd0;

        if (w_sweep) begin
            bus.ifu_icache_tag_cen_b  = 1'b0;
            bus.ifu_icache_tag_clk_en = 1'b1;
            bus.ifu_icache_tag_wen    = 3'b000;
            if (!cpurst) begin
                bus.ifu_icache_index[WIDTH:5] = r_cnt;
                bus.ifu_icache_inv_done       = w_last;
            end
        end else if (bus.refill_tag_wr_vld) begin
            bus.refill_tag_wr_gnt     = 1'b1;
            bus.ifu_icache_index      = bus.refill_tag_index;
            bus.ifu_icache_tag_cen_b  = 1'b0;
            bus.ifu_icache_tag_clk_en = 1'b1;
            if (bus.refill_tag_way) begin
                bus.ifu_icache_tag_din[57:29] = {1'b1, bus.refill_tag_value};
                bus.ifu_icache_tag_wen        = 3'b101;
            end else begin
                bus.ifu_icache_tag_din[28:0]  = {1'b1, bus.refill_tag_value};
                bus.ifu_icache_tag_wen        = 3'b110;
            end
        end else if (bus.lru_upd_vld) begin
            bus.lru_upd_gnt            = 1'b1;
            bus.ifu_icache_index       = bus.lru_upd_index;
            bus.ifu_icache_tag_cen_b   = 1'b0;
            bus.ifu_icache_tag_clk_en  = 1'b1;
            bus.ifu_icache_tag_din[58] = bus.lru_upd_bit;
            bus.ifu_icache_tag_wen     = 3'b011;
        end else if (bus.fetch_tag_rd_vld) begin
            bus.fetch_tag_rd_gnt      = 1'b1;
            bus.ifu_icache_index      = bus.fetch_tag_index;
            bus.ifu_icache_tag_cen_b  = 1'b0;
            bus.ifu_icache_tag_clk_en = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ct_ifu_icache_tag_req_arb.sv
// ============================================================================
// Module   : tb_ct_ifu_icache_tag_req_arb
// Brief    : Self-checking bench: vector table, corner sequences, random vs model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ct_ifu_icache_tag_req_arb;

    localparam int NSETS = 256;

    logic forever_cpuclk = 1'b0;
    logic cpurst         = 1'b1;
    always #5 forever_cpuclk = ~forever_cpuclk;

    ct_ifu_icache_tag_req_arb_if bus();

    ct_ifu_icache_tag_req_arb #(.WIDTH(12)) dut (
        .forever_cpuclk (forever_cpuclk),
        .cpurst         (cpurst),
        .bus            (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int sweep_left = 0;       // writes still owed by the reference model
    logic [83:0] obs;         // {done, gnt[2:0], index, cen_b, clk_en, wen, din}

    typedef struct {
        logic        rv;
        logic        rw;
        logic [15:0] ridx;
        logic [27:0] rval;
        logic        lv;
        logic [15:0] lidx;
        logic        lbit;
        logic        fv;
        logic [15:0] fidx;
        logic [83:0] exp;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [83:0] pack(logic done, logic [2:0] g, logic [15:0] idx,
                                         logic cen, logic ce, logic [2:0] wen, logic [58:0] din);
        return {done, g, idx, cen, ce, wen, din};
    endfunction

    function automatic logic [83:0] dut_out();
        return pack(bus.ifu_icache_inv_done,
                    {bus.refill_tag_wr_gnt, bus.lru_upd_gnt, bus.fetch_tag_rd_gnt},
                    bus.ifu_icache_index, bus.ifu_icache_tag_cen_b, bus.ifu_icache_tag_clk_en,
                    bus.ifu_icache_tag_wen, bus.ifu_icache_tag_din);
    endfunction

    // Expected array port for the current cycle from the written rules.
    function automatic logic [83:0] ref_out();
        if (cpurst)
            return pack(1'b0, 3'b000, 16'd0, 1'b0, 1'b1, 3'b000, 59'd0);
        if (sweep_left > 0)
            return pack(sweep_left == 1, 3'b000, 16'((NSETS - sweep_left) * 32),
                        1'b0, 1'b1, 3'b000, 59'd0);
        if (bus.refill_tag_wr_vld)
            return pack(1'b0, 3'b100, bus.refill_tag_index, 1'b0, 1'b1,
                        bus.refill_tag_way ? 3'b101 : 3'b110,
                        bus.refill_tag_way ? {1'b0, 1'b1, bus.refill_tag_value, 29'd0}
                                           : {30'd0, 1'b1, bus.refill_tag_value});
        if (bus.lru_upd_vld)
            return pack(1'b0, 3'b010, bus.lru_upd_index, 1'b0, 1'b1, 3'b011,
                        {bus.lru_upd_bit, 58'd0});
        if (bus.fetch_tag_rd_vld)
            return pack(1'b0, 3'b001, bus.fetch_tag_index, 1'b0, 1'b1, 3'b111, 59'd0);
        return pack(1'b0, 3'b000, 16'd0, 1'b1, 1'b0, 3'b111, 59'd0);
    endfunction

    task automatic check(string name, logic [83:0] act, logic [83:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare mid-cycle, then advance the model across the clock edge.
    task automatic tick(string name);
        #2;
        obs = dut_out();
        check(name, obs, ref_out());
        @(posedge forever_cpuclk);
        if (cpurst)               sweep_left = NSETS;
        else if (sweep_left > 0)  sweep_left--;
        else if (bus.cp0_ifu_icache_inv_req) sweep_left = NSETS;
        #1;
    endtask

    task automatic clear_reqs();
        bus.cp0_ifu_icache_inv_req = 1'b0;
        bus.refill_tag_wr_vld = 1'b0;
        bus.refill_tag_index  = 16'd0;
        bus.refill_tag_way    = 1'b0;
        bus.refill_tag_value  = 28'd0;
        bus.lru_upd_vld       = 1'b0;
        bus.lru_upd_index     = 16'd0;
        bus.lru_upd_bit       = 1'b0;
        bus.fetch_tag_rd_vld  = 1'b0;
        bus.fetch_tag_index   = 16'd0;
    endtask

    initial begin
        int writes;
        int dones;
        int done_set;
        int fgnt;

        vecs[0] = '{0, 0, 16'h0000, 28'h0, 0, 16'h0000, 0, 0, 16'h0000,
                    pack(0, 3'b000, 16'h0000, 1, 0, 3'b111, 59'd0)};
        vecs[1] = '{1, 0, 16'h1234, 28'h0000001, 0, 16'h0000, 0, 0, 16'h0000,
                    pack(0, 3'b100, 16'h1234, 0, 1, 3'b110, 59'h10000001)};
        vecs[2] = '{1, 1, 16'h0040, 28'hABCDEF1, 0, 16'h0000, 0, 0, 16'h0000,
                    pack(0, 3'b100, 16'h0040, 0, 1, 3'b101, {2'b01, 28'hABCDEF1, 29'd0})};
        vecs[3] = '{0, 0, 16'h0000, 28'h0, 1, 16'h0FF0, 1, 0, 16'h0000,
                    pack(0, 3'b010, 16'h0FF0, 0, 1, 3'b011, {1'b1, 58'd0})};
        vecs[4] = '{0, 0, 16'h0000, 28'h0, 1, 16'h0020, 0, 0, 16'h0000,
                    pack(0, 3'b010, 16'h0020, 0, 1, 3'b011, 59'd0)};
        vecs[5] = '{0, 0, 16'h0000, 28'h0, 0, 16'h0000, 0, 1, 16'hBEEF,
                    pack(0, 3'b001, 16'hBEEF, 0, 1, 3'b111, 59'd0)};
        vecs[6] = '{1, 0, 16'h0A0A, 28'hFFFFFFF, 1, 16'h1111, 1, 1, 16'h2222,
                    pack(0, 3'b100, 16'h0A0A, 0, 1, 3'b110, {30'd0, 29'h1FFFFFFF})};
        vecs[7] = '{0, 0, 16'h0000, 28'h0, 1, 16'h3333, 1, 1, 16'h4444,
                    pack(0, 3'b010, 16'h3333, 0, 1, 3'b011, {1'b1, 58'd0})};

        clear_reqs();
        cpurst = 1'b1;
        @(posedge forever_cpuclk);
        #1;

        // Reset held, then release with a fetch pending across the whole sweep.
        tick("reset_hold");
        tick("reset_hold2");
        check("reset_out", obs, pack(0, 3'b000, 16'd0, 0, 1, 3'b000, 59'd0));
        cpurst = 1'b0;
        bus.fetch_tag_rd_vld = 1'b1;
        bus.fetch_tag_index  = 16'h5555;
        writes = 0; dones = 0; done_set = -1; fgnt = 0;
        for (int k = 0; k < NSETS; k++) begin
            tick("init_sweep");
            if (k == 0) check("first_write_set0", obs, pack(0, 3'b000, 16'd0, 0, 1, 3'b000, 59'd0));
            if (obs[63] == 1'b0 && obs[61:59] == 3'b000) writes++;
            if (obs[83]) begin dones++; done_set = int'(obs[79:64]) / 32; end
            if (obs[80]) fgnt++;
        end
        check("init_writes", 84'(writes), 84'(NSETS));
        check("init_dones", 84'(dones), 84'd1);
        check("init_done_set", 84'(done_set), 84'(NSETS - 1));
        check("init_fetch_gnt", 84'(fgnt), 84'd0);
        tick("post_sweep_fetch");
        check("post_sweep_fetch_gnt", 84'(obs[82:80]), 84'(3'b001));
        clear_reqs();

        // Table of single-cycle IDLE accesses with hand-computed outputs.
        for (int i = 0; i < 8; i++) begin
            bus.refill_tag_wr_vld = vecs[i].rv;
            bus.refill_tag_way    = vecs[i].rw;
            bus.refill_tag_index  = vecs[i].ridx;
            bus.refill_tag_value  = vecs[i].rval;
            bus.lru_upd_vld       = vecs[i].lv;
            bus.lru_upd_index     = vecs[i].lidx;
            bus.lru_upd_bit       = vecs[i].lbit;
            bus.fetch_tag_rd_vld  = vecs[i].fv;
            bus.fetch_tag_index   = vecs[i].fidx;
            tick("vec_model");
            check($sformatf("vec%0d", i), obs, vecs[i].exp);
        end
        clear_reqs();

        // Three simultaneous requests drained one per cycle in priority order.
        bus.refill_tag_wr_vld = 1'b1; bus.refill_tag_index = 16'h0100;
        bus.lru_upd_vld = 1'b1; bus.lru_upd_index = 16'h0200; bus.lru_upd_bit = 1'b1;
        bus.fetch_tag_rd_vld = 1'b1; bus.fetch_tag_index = 16'h0300;
        tick("prio1");
        check("prio_refill", 84'(obs[82:80]), 84'(3'b100));
        bus.refill_tag_wr_vld = 1'b0;
        tick("prio2");
        check("prio_lru", 84'(obs[82:80]), 84'(3'b010));
        bus.lru_upd_vld = 1'b0;
        tick("prio3");
        check("prio_fetch", 84'(obs[82:80]), 84'(3'b001));
        clear_reqs();

        // inv_req re-pulsed at set 100 and on the final sweep cycle is merged.
        bus.cp0_ifu_icache_inv_req = 1'b1;
        tick("merge_start");
        dones = 0;
        for (int k = 0; k < NSETS; k++) begin
            bus.cp0_ifu_icache_inv_req = (k == 100 || k == NSETS - 1);
            tick("merge_sweep");
            if (obs[83]) dones++;
        end
        bus.cp0_ifu_icache_inv_req = 1'b0;
        check("merge_dones", 84'(dones), 84'd1);
        for (int k = 0; k < 3; k++) begin
            tick("merge_idle");
            check("merge_no_second_sweep", 84'(obs[63]), 84'd1);
        end

        // Reset at set 50 aborts the sweep without a done pulse.
        bus.cp0_ifu_icache_inv_req = 1'b1;
        tick("abort_start");
        bus.cp0_ifu_icache_inv_req = 1'b0;
        dones = 0;
        for (int k = 0; k < 50; k++) begin
            tick("abort_pre");
            if (obs[83]) dones++;
        end
        cpurst = 1'b1;
        tick("abort_rst");
        if (obs[83]) dones++;
        cpurst = 1'b0;
        done_set = -1;
        for (int k = 0; k < NSETS; k++) begin
            tick("abort_sweep");
            if (k == 0) check("abort_restart_set0", 84'(obs[79:64]), 84'd0);
            if (obs[83]) begin dones++; done_set = k; end
        end
        check("abort_dones", 84'(dones), 84'd1);
        check("abort_done_pos", 84'(done_set), 84'(NSETS - 1));

        // inv_req held two IDLE cycles alongside a fetch request.
        bus.fetch_tag_rd_vld = 1'b1; bus.fetch_tag_index = 16'h0777;
        bus.cp0_ifu_icache_inv_req = 1'b1;
        tick("inv_fetch1");
        check("inv_fetch_grant", 84'(obs[82:80]), 84'(3'b001));
        tick("inv_fetch2");
        check("inv_fetch_sweep0", pack(0, obs[82:80], obs[79:64], obs[63], 0, obs[61:59], 59'd0),
              pack(0, 3'b000, 16'd0, 0, 0, 3'b000, 59'd0));
        bus.cp0_ifu_icache_inv_req = 1'b0;
        dones = 0;
        for (int k = 1; k < NSETS; k++) begin
            tick("inv_fetch_sweep");
            if (obs[83]) dones++;
        end
        check("inv_fetch_dones", 84'(dones), 84'd1);
        tick("inv_fetch_after");
        check("inv_fetch_regrant", 84'(obs[82:80]), 84'(3'b001));
        clear_reqs();

        // Randomised traffic checked every cycle against the model.
        for (int k = 0; k < 3000; k++) begin
            bus.refill_tag_wr_vld = 1'($urandom_range(3) == 0);
            bus.refill_tag_way    = 1'($urandom);
            bus.refill_tag_index  = 16'($urandom);
            bus.refill_tag_value  = 28'($urandom);
            bus.lru_upd_vld       = 1'($urandom_range(2) == 0);
            bus.lru_upd_index     = 16'($urandom);
            bus.lru_upd_bit       = 1'($urandom);
            bus.fetch_tag_rd_vld  = 1'($urandom);
            bus.fetch_tag_index   = 16'($urandom);
            bus.cp0_ifu_icache_inv_req = ($urandom_range(199) == 0);
            cpurst = ($urandom_range(999) == 0);
            tick("random");
        end
        cpurst = 1'b0;
        clear_reqs();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ct_ifu_icache_tag_req_arb.md
CT_IFU_ICACHE_TAG_REQ_ARB -- requirements
Module: ct_ifu_icache_tag_req_arb

Interface
REQ-001 Parameter: WIDTH, 12, MSB of the set-index field in ifu_icache_index; set count is 2^(WIDTH-4).
REQ-002 Port: forever_cpuclk  in  1  clock; the only clock.
REQ-003 Port: cpurst  in  1  reset; synchronous, active-high.
REQ-004 Port: cp0_ifu_icache_inv_req  in  1  invalidate-all request, level; sampled each cycle.
REQ-005 Port: ifu_icache_inv_done  out  1  one-cycle pulse when a sweep completes.
REQ-006 Port: refill_tag_wr_vld / refill_tag_index[15:0] / refill_tag_way / refill_tag_value[27:0]  in  1/16/1/28  refill tag write.
REQ-007 Port: refill_tag_wr_gnt  out  1  refill write accepted this cycle.
REQ-008 Port: lru_upd_vld / lru_upd_index[15:0] / lru_upd_bit  in  1/16/1  LRU bit write.
REQ-009 Port: lru_upd_gnt  out  1  LRU write accepted this cycle.
REQ-010 Port: fetch_tag_rd_vld / fetch_tag_index[15:0]  in  1/16  fetch tag read.
REQ-011 Port: fetch_tag_rd_gnt  out  1  fetch read accepted this cycle.
REQ-012 Port: ifu_icache_index  out  16  array address.
REQ-013 Port: ifu_icache_tag_cen_b  out  1  array chip enable, active-low.
REQ-014 Port: ifu_icache_tag_clk_en  out  1  array clock-gate enable.
REQ-015 Port: ifu_icache_tag_din  out  59  write data.
REQ-016 Port: ifu_icache_tag_wen  out  3  active-low write enables {LRU bit 58, way1 bits 57:29, way0 bits 28:0}.

Function
REQ-017 Each way entry is 29 bits: {valid, tag[27:0]}.
REQ-018 Bit 58 holds the LRU bit.
REQ-019 States: SWEEP, IDLE.
REQ-020 Reset enters SWEEP with set counter = 0, so the array is initialised after every reset.
REQ-021 In SWEEP, every cycle drives one array access: cen_b=0, clk_en=1, wen=3'b000, din=0, index[WIDTH:5]=counter, all other index bits 0.
REQ-022 The set counter increments by 1 per SWEEP cycle.
REQ-023 On the cycle counter = 2^(WIDTH-4)-1, the last write is issued, the FSM moves to IDLE, the counter clears and ifu_icache_inv_done pulses for one cycle; there is no wrap past the last set.
REQ-024 IDLE -> SWEEP when cp0_ifu_icache_inv_req=1.
REQ-025 The first sweep write occurs the cycle after inv_req is sampled high.
REQ-026 inv_req high during SWEEP, including on the final sweep cycle, is merged: one sweep, one done pulse.
REQ-027 inv_req still high in IDLE after done starts a new sweep.
REQ-028 In SWEEP, all grants are 0.
REQ-029 In IDLE, fixed priority is refill write > LRU update > fetch read.
REQ-030 At most one grant is asserted per cycle.
REQ-031 Every grant is combinational from the request in the same cycle.
REQ-032 Refill grant: index = refill_tag_index; din places {1'b1, refill_tag_value} in the selected way field, other bits 0; wen clears only the selected way bit (way0 -> 3'b110, way1 -> 3'b101).
REQ-033 LRU grant: index = lru_upd_index; din[58] = lru_upd_bit, other bits 0; wen = 3'b011.
REQ-034 Fetch grant: index = fetch_tag_index; wen = 3'b111; din = 0.
REQ-035 Any grant drives cen_b=0 and clk_en=1.
REQ-036 With no access (IDLE, no request), drive cen_b=1, clk_en=0, wen=3'b111, index=0, din=0.
REQ-037 Requesters hold their request until granted; the block stores no request.

Reset
REQ-038 While cpurst=1 and on the first cycle after release, outputs are: inv_done=0, grants=0, cen_b=0, clk_en=1, wen=3'b000, index=0, din=0 (the first sweep write to set 0).
REQ-039 cpurst asserted mid-sweep restarts the sweep at set 0 and emits no done pulse for the aborted sweep.

Verification
REQ-040 Release reset with WIDTH=12 -> 256 consecutive writes to sets 0..255 with wen=000; inv_done pulses once, on the cycle set 255 is written; fetch_tag_rd_gnt stays 0 throughout.
REQ-041 In IDLE, refill, LRU and fetch requests in the same cycle -> refill_tag_wr_gnt=1 only, then lru_upd_gnt=1 the next cycle, then fetch_tag_rd_gnt=1 the cycle after.
REQ-042 Refill way1, index 0x0040, value 0xABCDEF1 -> wen=3'b101, din[57:29]={1,0xABCDEF1}, ifu_icache_index=0x0040.
REQ-043 inv_req pulsed at sweep set 100 and again on the final sweep cycle -> exactly one inv_done pulse and no second sweep.
REQ-044 cpurst pulsed at sweep set 50 -> next write targets set 0; a single done pulse follows 256 writes later.
REQ-045 In IDLE, inv_req held high for 2 cycles while fetch_tag_rd_vld=1 -> fetch granted on the request cycle only; the sweep starts the next cycle and runs to a single done pulse.
